life_game_engine: RTL and testbench
===================================

// Module: life_game_engine
// PURPOSE
//  Hardware next-generation engine for the life game cell store (bus initiator on the cell port).
//  On start it reads the displayed world, one 32-bit word per cycle, and computes Conway's rules.
//  It writes the next generation back through the same port.
//  The cell store routes those writes to the hidden buffer; the buffers swap on world_clock.
//  This replaces the CPU software loop that drives cell_write today.
// PARAMETERS
//  ROWS        48  world height in rows; width fixed at 64 cells = 2 words/row
//  ADDR_WIDTH  7   cell word address width; address = {row[5:0], half}
// PORTS
//  clock            in   1   system clock, all logic on posedge
//  reset_n          in   1   asynchronous, active-low reset
//  start            in   1   1-cycle pulse: compute one generation
//  busy             out  1   high while a generation is in progress
//  done             out  1   1-cycle pulse after the last write of a generation
//  cell_address     out  7   word address to cell store (read and write share it)
//  cell_read_data   in   32  cell store cell_data_out; combinational, valid same cycle as address
//  cell_write       out  1   write strobe, 1 cycle per word
//  cell_write_data  out  32  next-generation word for cell_address
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; busy=0, done=0, cell_write=0, cell_address=0, data=0, row regs=0.
//  Bit map: word {y,0} bit i = cell (x=i,y); word {y,1} bit i = cell (x=32+i,y).
//  Rule: next = (n==3) | (alive & n==2); n = live count of the 8 neighbours, 4-bit sum.
//  Window: three 64-bit regs prev/cur/nxt = rows y-1, y, y+1; all 64 next bits combinational.
//  FSM:
//   IDLE: start=1 -> PRE0. Start seen at edge 0; busy=1 from cycle 1.
//   PRE0..PRE5: 6 reads, in order: halo row ROWS-1 lo/hi -> prev; row 0 lo/hi -> cur; row 1 lo/hi -> nxt.
//   WR_LO, WR_HI: cell_write=1, address {y,0} then {y,1}; data = next-gen bits 31:0 / 63:32.
//   After WR_HI: if y==ROWS-1 -> DONE.
//   Otherwise shift prev<=cur, cur<=nxt, y<=y+1 -> FE_LO, FE_HI.
//   FE_LO, FE_HI: read row y+1 into nxt. When y+1==ROWS, this is the bottom halo row. Then -> WR_LO.
//   DONE: done=1 for one cycle, busy=0 -> IDLE.
//  Timing, ROWS=48: busy high cycles 1..196; 96 writes to addresses 0..95 ascending; done in cycle 197.
//  The engine never writes and reads in the same cycle; cell_write=0 in every read state.
//  Boundaries:
//   start while busy or in DONE is ignored. No queueing.
//   reset_n low mid-run: immediate abort to IDLE. Partially written hidden buffer is left as is.
//   The world must not swap (world_clock) while busy. System software gates start on world_clock.
//   Row counter wraps only through the halo logic; y never exceeds ROWS-1.
// CONFIGURATION
//  LIFE_GAME_TORUS_EN defined: wrap-around world.
//   Halo rows are real rows: top halo = row ROWS-1, bottom halo = row 0.
//   Column 63 is adjacent to column 0.
//  LIFE_GAME_TORUS_EN undefined: cells outside the world are dead.
//   Halo reads still occur for fixed timing; the read data is forced to 0.
//   Out-of-range column neighbours = 0.
// TESTING
//  1 Blinker: word 20=0x000000E0 (row 10, x5..7), all else 0
//    -> writes word 18=0x40, 20=0x40, 22=0x40; all others 0.
//  2 Block across the half boundary: words 10,12=0x80000000; words 11,13=0x00000001
//    -> identical words written back, all others 0.
//  3 Edge: word 0=0x00000007 (row 0, x0..2)
//    -> without TORUS_EN: word 0=0x2, word 2=0x2, word 94=0.
//    -> with TORUS_EN: words 0, 2, 94 = 0x2.
//  4 Timing: empty world, start pulse -> busy cycles 1..196; exactly 96 cell_write pulses.
//    Addresses 0..95 ascending, all data 0; done pulse in cycle 197 only.
//  5 Extra start in cycle 50 ignored: still 96 writes.
//    reset_n low at cycle 100 -> cell_write, busy = 0 at once.
//    Next start then runs a full 196-cycle generation.
//  6 Glider, 4 generations with buffer swap between runs (model store): pattern shifted by (+1,+1).

Source files
------------

// File: rtl/life_game_if.sv
// Cell-port bundle of the life game engine: start/busy/done control plus
// the shared read/write word port to the cell store.
// master = the engine (bus initiator), slave = the cell store / controller.
interface life_game_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] cell_address;
    logic [31:0]           cell_read_data;
    logic                  cell_write;
    logic [31:0]           cell_write_data;

    modport master (
        input  start, cell_read_data,
        output busy, done, cell_address, cell_write, cell_write_data
    );

    modport slave (
        output start, cell_read_data,
        input  busy, done, cell_address, cell_write, cell_write_data
    );
endinterface

// File: rtl/life_game_engine.sv
// Next-generation engine for the life game cell store.
// Streams the displayed world row by row through a three-row window
// (prev/cur/nxt), computes Conway's rule for all 64 columns at once and
// writes each row back as two 32-bit words.
// Build option: define LIFE_GAME_TORUS_EN for a wrap-around world; otherwise
// cells outside the world are dead (halo reads are still issued, data zeroed).
module life_game_engine #(
    parameter int ROWS       = 48,
    parameter int ADDR_WIDTH = 7
) (
    input  logic          clock,
    input  logic          reset_n,
    life_game_if.master   bus
);
    localparam int ROW_W = ADDR_WIDTH - 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE0, S_PRE1, S_PRE2, S_PRE3, S_PRE4, S_PRE5,
        S_WR_LO, S_WR_HI, S_FE_LO, S_FE_HI, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] y_q, y_d;
    logic [63:0]      prev_q, prev_d;
    logic [63:0]      cur_q, cur_d;
    logic [63:0]      nxt_q, nxt_d;

    logic [ROW_W-1:0] rd_row;
    logic             rd_half;
    logic             rd_halo;
    logic [31:0]      rd_data;
    logic [63:0]      next_gen;
    logic [65:0]      prev_x, cur_x, nxt_x;

`ifdef LIFE_GAME_TORUS_EN
    // Halo rows are real rows and the columns wrap around.
    logic unused_halo;
    assign unused_halo = rd_halo;
    assign rd_data = bus.cell_read_data;
    assign prev_x  = {prev_q[0], prev_q, prev_q[63]};
    assign cur_x   = {cur_q[0],  cur_q,  cur_q[63]};
    assign nxt_x   = {nxt_q[0],  nxt_q,  nxt_q[63]};
`else
    // Outside the world everything is dead: zero halo rows and edge columns.
    assign rd_data = rd_halo ? 32'd0 : bus.cell_read_data;
    assign prev_x  = {1'b0, prev_q, 1'b0};
    assign cur_x   = {1'b0, cur_q,  1'b0};
    assign nxt_x   = {1'b0, nxt_q,  1'b0};
`endif

    // Conway's rule per column; extended index x+1 holds column x.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_cell
            logic [3:0] n;
            assign n = {3'd0, prev_x[gi]} + {3'd0, prev_x[gi+1]} + {3'd0, prev_x[gi+2]}
                     + {3'd0, cur_x[gi]}                          + {3'd0, cur_x[gi+2]}
                     + {3'd0, nxt_x[gi]}  + {3'd0, nxt_x[gi+1]}  + {3'd0, nxt_x[gi+2]};
            assign next_gen[gi] = (n == 4'd3) | (cur_q[gi] & (n == 4'd2));
        end
    endgenerate

    // State and window registers; async abort returns everything to idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
        end
    end

    // Next-state sequencing: preload, then write/fetch pairs per row.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_PRE0;
            S_PRE0:  state_d = S_PRE1;
            S_PRE1:  state_d = S_PRE2;
            S_PRE2:  state_d = S_PRE3;
            S_PRE3:  state_d = S_PRE4;
            S_PRE4:  state_d = S_PRE5;
            S_PRE5:  state_d = S_WR_LO;
            S_WR_LO: state_d = S_WR_HI;
            S_WR_HI: state_d = (y_q == LAST_ROW) ? S_DONE : S_FE_LO;
            S_FE_LO: state_d = S_FE_HI;
            S_FE_HI: state_d = S_WR_LO;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read address selection; the bottom halo is row 0 (zeroed when not a torus).
    always_comb begin
        rd_row  = '0;
        rd_half = 1'b0;
        rd_halo = 1'b0;
        case (state_q)
            S_PRE0:  begin rd_row = LAST_ROW; rd_halo = 1'b1; end
            S_PRE1:  begin rd_row = LAST_ROW; rd_halo = 1'b1; rd_half = 1'b1; end
            S_PRE3:  rd_half = 1'b1;
            S_PRE4:  rd_row = ROW_W'(1);
            S_PRE5:  begin rd_row = ROW_W'(1); rd_half = 1'b1; end
            S_FE_LO, S_FE_HI: begin
                rd_half = (state_q == S_FE_HI);
                if (y_q == LAST_ROW) begin
                    rd_row  = '0;
                    rd_halo = 1'b1;
                end else begin
                    rd_row = y_q + ROW_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Window loading and row advance.
    always_comb begin
        y_d    = y_q;
        prev_d = prev_q;
        cur_d  = cur_q;
        nxt_d  = nxt_q;
        case (state_q)
            S_IDLE:  if (bus.start) y_d = '0;
            S_PRE0:  prev_d[31:0]  = rd_data;
            S_PRE1:  prev_d[63:32] = rd_data;
            S_PRE2:  cur_d[31:0]   = rd_data;
            S_PRE3:  cur_d[63:32]  = rd_data;
            S_PRE4:  nxt_d[31:0]   = rd_data;
            S_PRE5:  nxt_d[63:32]  = rd_data;
            S_FE_LO: nxt_d[31:0]   = rd_data;
            S_FE_HI: nxt_d[63:32]  = rd_data;
            S_WR_HI: begin
                if (y_q != LAST_ROW) begin
                    prev_d = cur_q;
                    cur_d  = nxt_q;
                    y_d    = y_q + ROW_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Bus outputs decoded from the current state.
    always_comb begin
        bus.busy            = (state_q != S_IDLE) && (state_q != S_DONE);
        bus.done            = (state_q == S_DONE);
        bus.cell_write      = 1'b0;
        bus.cell_address    = '0;
        bus.cell_write_data = 32'd0;
        case (state_q)
            S_WR_LO: begin
                bus.cell_write      = 1'b1;
                bus.cell_address    = {y_q, 1'b0};
                bus.cell_write_data = next_gen[31:0];
            end
            S_WR_HI: begin
                bus.cell_write      = 1'b1;
                bus.cell_address    = {y_q, 1'b1};
                bus.cell_write_data = next_gen[63:32];
            end
            S_PRE0, S_PRE1, S_PRE2, S_PRE3, S_PRE4, S_PRE5, S_FE_LO, S_FE_HI:
                bus.cell_address = {rd_row, rd_half};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_life_game_engine.sv
// Self-checking bench for life_game_engine: a two-buffer model cell store,
// a table of pattern vectors, plus timing, abort and glider sequences.
module tb_life_game_engine;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    life_game_if #(.ADDR_WIDTH(7)) bus();

    life_game_engine #(.ROWS(48), .ADDR_WIDTH(7)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // Model store: displayed buffer is read combinationally, hidden buffer
    // collects the writes (recorded by the run task as they happen).
    logic [31:0] disp_mem [128];
    logic [31:0] hid_mem  [128];
    logic [31:0] exp_mem  [96];
    assign bus.cell_read_data = disp_mem[bus.cell_address];

    int checks = 0;
    int failures = 0;

    int wr_cnt, bad_addr, nonzero_data;
    int busy_first, busy_last, busy_cnt, done_first, done_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%h expected=0x%h", name, got, exp);
        end
    endtask

    task automatic clear_disp();
        for (int i = 0; i < 128; i++) disp_mem[i] = 32'd0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 96; i++) exp_mem[i] = 32'd0;
    endtask

    task automatic set_cell(input int x, input int y);
        disp_mem[y*2 + x/32][x%32] = 1'b1;
    endtask

    task automatic set_exp(input int x, input int y);
        exp_mem[y*2 + x/32][x%32] = 1'b1;
    endtask

    // One generation: start pulse, then one sample per cycle at the falling
    // edge. extra_c: cycle in which a second start is driven (0 = none);
    // rst_c: cycle in which reset_n is pulled low (0 = none).
    task automatic run_gen(input int extra_c, input int rst_c);
        wr_cnt = 0; bad_addr = 0; nonzero_data = 0;
        busy_first = 0; busy_last = 0; busy_cnt = 0; done_first = 0; done_cnt = 0;
        for (int i = 0; i < 128; i++) hid_mem[i] = 32'hDEADBEEF;
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int c = 1; c <= 260; c++) begin
            if (c == rst_c) begin
                reset_n = 1'b0;
                #1;
                check("abort_busy",  32'(bus.busy), 32'd0);
                check("abort_write", 32'(bus.cell_write), 32'd0);
                @(negedge clock);
                reset_n = 1'b1;
                break;
            end
            if (bus.busy) begin
                if (busy_cnt == 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
            end
            if (bus.done) begin
                if (done_cnt == 0) done_first = c;
                done_cnt++;
            end
            if (bus.cell_write) begin
                if (int'(bus.cell_address) != wr_cnt) bad_addr++;
                if (bus.cell_write_data != 32'd0) nonzero_data++;
                hid_mem[bus.cell_address] = bus.cell_write_data;
                wr_cnt++;
            end
            bus.start = (c == extra_c);
            if (done_cnt > 0 && c >= done_first + 3) break;
            @(negedge clock);
        end
        bus.start = 1'b0;
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_busy_first"}, busy_first, 1);
        check({tag, "_busy_last"},  busy_last, 196);
        check({tag, "_busy_cnt"},   busy_cnt, 196);
        check({tag, "_done_cycle"}, done_first, 197);
        check({tag, "_done_cnt"},   done_cnt, 1);
        check({tag, "_writes"},     wr_cnt, 96);
        check({tag, "_addr_order"}, bad_addr, 0);
    endtask

    typedef struct {
        string              name;
        int                 n_in;
        logic [3:0][6:0]    in_addr;
        logic [3:0][31:0]   in_data;
        int                 n_exp;
        logic [3:0][6:0]    exp_addr;
        logic [3:0][31:0]   exp_data;
    } vec_t;

    vec_t vecs [3];

    initial begin
        bus.start = 1'b0;
        clear_disp();

        // Directed pattern table.
        vecs[0].name = "blinker";
        vecs[0].n_in = 1;
        vecs[0].in_addr[0] = 7'd20; vecs[0].in_data[0] = 32'h0000_00E0;
        vecs[0].n_exp = 3;
        vecs[0].exp_addr[0] = 7'd18; vecs[0].exp_data[0] = 32'h40;
        vecs[0].exp_addr[1] = 7'd20; vecs[0].exp_data[1] = 32'h40;
        vecs[0].exp_addr[2] = 7'd22; vecs[0].exp_data[2] = 32'h40;

        vecs[1].name = "block";
        vecs[1].n_in = 4;
        vecs[1].in_addr[0] = 7'd10; vecs[1].in_data[0] = 32'h8000_0000;
        vecs[1].in_addr[1] = 7'd12; vecs[1].in_data[1] = 32'h8000_0000;
        vecs[1].in_addr[2] = 7'd11; vecs[1].in_data[2] = 32'h0000_0001;
        vecs[1].in_addr[3] = 7'd13; vecs[1].in_data[3] = 32'h0000_0001;
        vecs[1].n_exp = 4;
        vecs[1].exp_addr = vecs[1].in_addr;
        vecs[1].exp_data = vecs[1].in_data;

        vecs[2].name = "edge";
        vecs[2].n_in = 1;
        vecs[2].in_addr[0] = 7'd0; vecs[2].in_data[0] = 32'h0000_0007;
        vecs[2].exp_addr[0] = 7'd0; vecs[2].exp_data[0] = 32'h2;
        vecs[2].exp_addr[1] = 7'd2; vecs[2].exp_data[1] = 32'h2;
`ifdef LIFE_GAME_TORUS_EN
        vecs[2].n_exp = 3;
        vecs[2].exp_addr[2] = 7'd94; vecs[2].exp_data[2] = 32'h2;
`else
        vecs[2].n_exp = 2;
`endif

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_done",  32'(bus.done), 32'd0);
        check("rst_write", 32'(bus.cell_write), 32'd0);
        check("rst_addr",  32'(bus.cell_address), 32'd0);
        check("rst_data",  bus.cell_write_data, 32'd0);
        reset_n = 1'b1;

        // Empty world: cycle-exact timing.
        run_gen(0, 0);
        check_timing("empty");
        check("empty_data", nonzero_data, 0);
        $display("gen empty: writes=%0d busy=%0d..%0d done@%0d", wr_cnt, busy_first, busy_last, done_first);

        // Pattern vectors.
        for (int v = 0; v < 3; v++) begin
            clear_disp();
            clear_exp();
            for (int k = 0; k < vecs[v].n_in; k++) disp_mem[vecs[v].in_addr[k]] = vecs[v].in_data[k];
            for (int k = 0; k < vecs[v].n_exp; k++) exp_mem[vecs[v].exp_addr[k]] = vecs[v].exp_data[k];
            run_gen(0, 0);
            check({vecs[v].name, "_writes"}, wr_cnt, 96);
            for (int w = 0; w < 96; w++)
                check($sformatf("%s_w%0d", vecs[v].name, w), hid_mem[w], exp_mem[w]);
            $display("gen %s: writes=%0d done@%0d", vecs[v].name, wr_cnt, done_first);
        end

        // Extra start mid-run is ignored.
        clear_disp();
        run_gen(50, 0);
        check_timing("extra_start");
        $display("gen extra_start: writes=%0d busy_cnt=%0d", wr_cnt, busy_cnt);

        // Reset mid-run aborts at once; rows 0..22 plus row 23 low word written.
        run_gen(0, 100);
        check("abort_writes", wr_cnt, 47);
        check("abort_done", done_cnt, 0);
        $display("gen abort: writes_before_reset=%0d", wr_cnt);

        // Next start after the abort runs a full generation.
        run_gen(0, 0);
        check_timing("after_abort");
        $display("gen after_abort: writes=%0d busy_cnt=%0d", wr_cnt, busy_cnt);

        // Glider straddling the half-word boundary, 4 generations with swap.
        clear_disp();
        set_cell(31, 20); set_cell(32, 21); set_cell(30, 22); set_cell(31, 22); set_cell(32, 22);
        for (int g = 0; g < 4; g++) begin
            run_gen(0, 0);
            check($sformatf("glider_g%0d_writes", g), wr_cnt, 96);
            for (int i = 0; i < 96; i++) disp_mem[i] = hid_mem[i];
            $display("gen glider %0d: writes=%0d", g, wr_cnt);
        end
        clear_exp();
        set_exp(32, 21); set_exp(33, 22); set_exp(31, 23); set_exp(32, 23); set_exp(33, 23);
        for (int w = 0; w < 96; w++)
            check($sformatf("glider_w%0d", w), disp_mem[w], exp_mem[w]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
